alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Initiator side of the ALU: accepts one ALU command over a valid/ready handshake and sequences the ALU control phases.
//  It builds the operands, the SM83 opcode byte and the control strobe vector, then drives the precharge, evaluate and flag-load phases.
//  It returns the result byte and the Z/N/H/C flags over a valid/ready response channel.
//  Sits between the bench/microsequencer and the ALU; used to exercise the ALU standalone.
// PARAMETERS
//  EVAL_CYCLES  1  number of cycles alu_eval stays high (1..4)
//  CTL_W        24 width of alu_ctl strobe vector (fixed bit map below)
// PORTS
//  CLK         in  1  clock; all state on rising edge
//  nRESET      in  1  asynchronous, active-low reset
//  cmd_valid   in  1  command present
//  cmd_ready   out 1  issuer can accept command
//  cmd_op      in  5  op: 0 ADD,1 ADC,2 SUB,3 SBC,4 AND,5 XOR,6 OR,7 CP,8 INC,9 DEC,10 RLC,11 RRC,12 RL,13 RR,14 SLA,15 SRA,16 SWAP,17 SRL,18 BIT,19 RES,20 SET,21 DAA,22 CPL,23 SCF,24 CCF
//  cmd_bit     in  3  bit index for BIT/RES/SET, ignored otherwise
//  cmd_a       in  8  operand 1 (accumulator / target)
//  cmd_b       in  8  operand 2
//  alu_opnd1   out 8  ALU operand 1
//  alu_opnd2   out 8  ALU operand 2
//  alu_ir      out 8  SM83 opcode byte presented as IR (nIR = ~alu_ir[5:0] is derived downstream)
//  alu_ctl     out 24 control strobes: 0 sum,1 xor,2 logic_and,3 logic_or,4 b_complement,5 rot_shl,6 rot_shr,7 rlc,8 rl,9 rrc,10 rr,11 sra,12 swap,13 cb_bit,14 set,15 res,16 daa,17 cpl,18 ccf_scf,19 wren_hf_nf_zf,20 wren_cf,21 add_adc,22 sub_sbc,23 cp
//  alu_precharge out 1 precharge phase of the ALU dynamic logic
//  alu_eval    out 1  evaluate phase
//  alu_flag_load out 1 Load strobe of the flag latches
//  alu_res     in  8  ALU result
//  alu_flags   in  4  {Z,N,H,C} from the ALU flag latches
//  rsp_valid   out 1  response present
//  rsp_ready   in  1  consumer accepts response
//  rsp_res     out 8  captured result
//  rsp_flags   out 4  captured {Z,N,H,C}
//  rsp_err     out 1  illegal op (cmd_op>24)
// BEHAVIOUR
//  - Reset values: all outputs 0 except cmd_ready=1. FSM goes to IDLE and the captured flags clear to 0.
//    Reset asserted mid-operation aborts the command: no response is produced and strobes drop immediately.
//  - FSM states: IDLE, PRE, EVAL, LOAD, CAPT, RESP.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register the command, opnd1/opnd2, alu_ir and alu_ctl.
//    Legal op -> PRE. Illegal op -> RESP with rsp_err=1, rsp_res=0, rsp_flags=previous capture, no ALU strobes.
//  - PRE: alu_precharge=1 for one cycle -> EVAL.
//  - EVAL: alu_eval=1 for EVAL_CYCLES cycles. alu_res is captured into rsp_res on the last EVAL edge -> LOAD.
//  - LOAD: alu_flag_load=1 for one cycle, only if ctl[19]|ctl[20]; otherwise flag_load stays 0 -> CAPT.
//  - CAPT: alu_flags captured into rsp_flags -> RESP.
//  - RESP: rsp_valid=1; rsp_res, rsp_flags and rsp_err are held stable until rsp_ready. On the handshake -> IDLE.
//  - cmd_ready=0 in every state except IDLE, so no command is accepted in the same cycle as the response handshake.
//  - alu_opnd*, alu_ir and alu_ctl are held constant from PRE through CAPT and return to 0 in IDLE/RESP.
//  - Latency: the accept edge is T; rsp_valid rises at T+4+EVAL_CYCLES (T+5 by default).
//  - alu_ir values:
//    - ops 0..7: 0x87|op<<3 (for example SUB=0x97, CP=0xBF)
//    - INC=0x3C, DEC=0x3D, DAA=0x27, CPL=0x2F, SCF=0x37, CCF=0x3F
//    - CB rotates/shifts (ops 10..17): (op-10)<<3|7
//    - BIT=0x47|bit<<3, RES=0x87|bit<<3, SET=0xC7|bit<<3
//  - alu_ctl per op; every op also sets bit 19 (wren_hf_nf_zf) unless noted:
//    - ADD/ADC: 0,21,20
//    - SUB/SBC: 0,4,22,20
//    - CP: 0,4,23,20
//    - AND: 2,20
//    - XOR: 1,20
//    - OR: 3,20
//    - INC/DEC: 0 (DEC adds 4); no bit 20
//    - Rotates: RLC 5,7; RRC 6,9; RL 5,8; RR 6,10; SLA 5; SRA 6,11; SRL 6; SWAP 12; all also set 20
//    - BIT: 13; no bit 20
//    - RES: 15, SET: 14; neither sets bit 19 nor bit 20
//    - DAA: 0,16,20
//    - CPL: 17; no bit 20
//    - SCF/CCF: 18,20
//  - All arithmetic is performed by the ALU; the issuer never computes results itself and only captures them.
// TESTING
//  1) ADD a=0x3A b=0xC6 -> alu_ir=0x87, rsp_res=0x00, flags Z1 N0 H1 C1; rsp_valid exactly 5 cycles after accept.
//  2) BIT bit=7 b=0x80 -> alu_ir=0x7F, no wren_cf, flags Z0 N0 H1 with C unchanged; alu_flag_load pulses once.
//  3) SET bit=3 a=0x00 -> alu_ir=0xDF, rsp_res=0x08, alu_flag_load stays 0 for the whole command.
//  4) rsp_ready held low 3 cycles -> rsp_valid/res/flags stable, cmd_ready=0, cmd_valid ignored; handshake -> IDLE next cycle.
//  5) cmd_op=31 -> rsp_err=1, rsp_res=0, no precharge/eval/load pulses, rsp_valid on the cycle after accept.
//  6) nRESET low during EVAL -> all outputs 0 and cmd_ready=1 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Command-to-phase sequencer for the standalone ALU: decodes one command into operands,
// SM83 opcode and control strobes, steps precharge/evaluate/flag-load, and returns the captured result.
module alu_op_issuer #(
    parameter int EVAL_CYCLES = 1,
    parameter int CTL_W       = 24
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [2:0]       cmd_bit,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic [7:0]       alu_opnd1,
    output logic [7:0]       alu_opnd2,
    output logic [7:0]       alu_ir,
    output logic [CTL_W-1:0] alu_ctl,
    output logic             alu_precharge,
    output logic             alu_eval,
    output logic             alu_flag_load,
    input  logic [7:0]       alu_res,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_res,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    localparam int CTL_SUM      = 0;
    localparam int CTL_XOR      = 1;
    localparam int CTL_AND      = 2;
    localparam int CTL_OR       = 3;
    localparam int CTL_BCOMP    = 4;
    localparam int CTL_SHL      = 5;
    localparam int CTL_SHR      = 6;
    localparam int CTL_RLC      = 7;
    localparam int CTL_RL       = 8;
    localparam int CTL_RRC      = 9;
    localparam int CTL_RR       = 10;
    localparam int CTL_SRA      = 11;
    localparam int CTL_SWAP     = 12;
    localparam int CTL_CB_BIT   = 13;
    localparam int CTL_SET      = 14;
    localparam int CTL_RES      = 15;
    localparam int CTL_DAA      = 16;
    localparam int CTL_CPL      = 17;
    localparam int CTL_CCF_SCF  = 18;
    localparam int CTL_WREN_HNZ = 19;
    localparam int CTL_WREN_CF  = 20;
    localparam int CTL_ADD_ADC  = 21;
    localparam int CTL_SUB_SBC  = 22;
    localparam int CTL_CP       = 23;

    localparam logic [1:0] EVAL_LAST = 2'(EVAL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_EVAL,
        ST_LOAD,
        ST_CAPT,
        ST_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_opnd1;
    logic [7:0]       r_opnd2;
    logic [7:0]       r_ir;
    logic [CTL_W-1:0] r_ctl;
    logic [1:0]       r_eval_cnt;
    logic [7:0]       r_rsp_res;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;

    logic [7:0]       w_ir;
    logic [CTL_W-1:0] w_ctl;
    logic             w_legal;
    logic             w_drive;
    logic             w_eval_last;

    // Opcode/strobe decode of the incoming command; consumed only on the accept edge.
    always_comb begin
        w_ir    = '0;
        w_ctl   = '0;
        w_legal = 1'b1;
        case (cmd_op)
            5'd0, 5'd1: begin
                w_ir = {2'b10, cmd_op[2:0], 3'b111};
                w_ctl[CTL_SUM] = 1'b1;
                w_ctl[CTL_ADD_ADC] = 1'b1;
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            5'd2, 5'd3: begin
                w_ir = {2'b10, cmd_op[2:0], 3'b111};
                w_ctl[CTL_SUM] = 1'b1;
                w_ctl[CTL_BCOMP] = 1'b1;
                w_ctl[CTL_SUB_SBC] = 1'b1;
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            5'd4, 5'd5, 5'd6: begin
                w_ir = {2'b10, cmd_op[2:0], 3'b111};
                w_ctl[CTL_AND] = (cmd_op == 5'd4);
                w_ctl[CTL_XOR] = (cmd_op == 5'd5);
                w_ctl[CTL_OR]  = (cmd_op == 5'd6);
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            5'd7: begin
                w_ir = 8'hBF;
                w_ctl[CTL_SUM] = 1'b1;
                w_ctl[CTL_BCOMP] = 1'b1;
                w_ctl[CTL_CP] = 1'b1;
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            5'd8: begin
                w_ir = 8'h3C;
                w_ctl[CTL_SUM] = 1'b1;
            end
            5'd9: begin
                w_ir = 8'h3D;
                w_ctl[CTL_SUM] = 1'b1;
                w_ctl[CTL_BCOMP] = 1'b1;
            end
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17: begin
                // (op-10) mod 8 equals op[2:0]+6 mod 8 across this range.
                w_ir = {2'b00, 3'(cmd_op[2:0] + 3'd6), 3'b111};
                w_ctl[CTL_WREN_CF] = 1'b1;
                w_ctl[CTL_SHL]  = (cmd_op == 5'd10) || (cmd_op == 5'd12) || (cmd_op == 5'd14);
                w_ctl[CTL_SHR]  = (cmd_op == 5'd11) || (cmd_op == 5'd13) || (cmd_op == 5'd15)
                                  || (cmd_op == 5'd17);
                w_ctl[CTL_RLC]  = (cmd_op == 5'd10);
                w_ctl[CTL_RRC]  = (cmd_op == 5'd11);
                w_ctl[CTL_RL]   = (cmd_op == 5'd12);
                w_ctl[CTL_RR]   = (cmd_op == 5'd13);
                w_ctl[CTL_SRA]  = (cmd_op == 5'd15);
                w_ctl[CTL_SWAP] = (cmd_op == 5'd16);
            end
            5'd18: begin
                w_ir = {2'b01, cmd_bit, 3'b111};
                w_ctl[CTL_CB_BIT] = 1'b1;
            end
            5'd19: begin
                w_ir = {2'b10, cmd_bit, 3'b111};
                w_ctl[CTL_RES] = 1'b1;
            end
            5'd20: begin
                w_ir = {2'b11, cmd_bit, 3'b111};
                w_ctl[CTL_SET] = 1'b1;
            end
            5'd21: begin
                w_ir = 8'h27;
                w_ctl[CTL_SUM] = 1'b1;
                w_ctl[CTL_DAA] = 1'b1;
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            5'd22: begin
                w_ir = 8'h2F;
                w_ctl[CTL_CPL] = 1'b1;
            end
            5'd23, 5'd24: begin
                w_ir = (cmd_op == 5'd23) ? 8'h37 : 8'h3F;
                w_ctl[CTL_CCF_SCF] = 1'b1;
                w_ctl[CTL_WREN_CF] = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        // Bit set/reset leave every flag untouched.
        w_ctl[CTL_WREN_HNZ] = w_legal && (cmd_op != 5'd19) && (cmd_op != 5'd20);
    end

    assign w_eval_last = (r_eval_cnt == EVAL_LAST);

    always_comb begin
        w_state_next  = r_state;
        cmd_ready     = 1'b0;
        alu_precharge = 1'b0;
        alu_eval      = 1'b0;
        alu_flag_load = 1'b0;
        rsp_valid     = 1'b0;
        w_drive       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = w_legal ? ST_PRE : ST_RESP;
                end
            end
            ST_PRE: begin
                alu_precharge = 1'b1;
                w_drive       = 1'b1;
                w_state_next  = ST_EVAL;
            end
            ST_EVAL: begin
                alu_eval = 1'b1;
                w_drive  = 1'b1;
                if (w_eval_last) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                alu_flag_load = r_ctl[CTL_WREN_HNZ] | r_ctl[CTL_WREN_CF];
                w_drive       = 1'b1;
                w_state_next  = ST_CAPT;
            end
            ST_CAPT: begin
                w_drive      = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= ST_IDLE;
            r_opnd1     <= '0;
            r_opnd2     <= '0;
            r_ir        <= '0;
            r_ctl       <= '0;
            r_eval_cnt  <= '0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_opnd1    <= cmd_a;
                        r_opnd2    <= cmd_b;
                        r_ir       <= w_ir;
                        r_ctl      <= w_ctl;
                        r_eval_cnt <= '0;
                        r_rsp_err  <= ~w_legal;
                        if (!w_legal) begin
                            r_rsp_res <= '0;
                        end
                    end
                end
                ST_EVAL: begin
                    r_eval_cnt <= r_eval_cnt + 2'd1;
                    if (w_eval_last) begin
                        r_rsp_res <= alu_res;
                    end
                end
                ST_CAPT: r_rsp_flags <= alu_flags;
                default: ;
            endcase
        end
    end

    assign alu_opnd1 = w_drive ? r_opnd1 : '0;
    assign alu_opnd2 = w_drive ? r_opnd2 : '0;
    assign alu_ir    = w_drive ? r_ir    : '0;
    assign alu_ctl   = w_drive ? r_ctl   : '0;
    assign rsp_res   = r_rsp_res;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed scenarios plus random commands, with an SM83-style ALU
// stand-in and flag latch whose expectations come from plain instruction semantics.
module tb_alu_op_issuer;

    localparam int EC = 1;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_bit;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_opnd1;
    logic [7:0]  alu_opnd2;
    logic [7:0]  alu_ir;
    logic [23:0] alu_ctl;
    logic        alu_precharge;
    logic        alu_eval;
    logic        alu_flag_load;
    logic [7:0]  alu_res;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_res;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    logic [7:0]  cur_res;
    logic [7:0]  noise_res;
    logic [3:0]  cur_flags;
    logic [3:0]  flag_latch;
    logic [3:0]  last_rsp_flags;
    logic [7:0]  got_res;
    logic [3:0]  got_flags;
    int          tests;
    int          fails;

    alu_op_issuer #(.EVAL_CYCLES(EC), .CTL_W(24)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opnd1(alu_opnd1), .alu_opnd2(alu_opnd2), .alu_ir(alu_ir), .alu_ctl(alu_ctl),
        .alu_precharge(alu_precharge), .alu_eval(alu_eval), .alu_flag_load(alu_flag_load),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: result only valid while evaluating, flags come from a latch loaded by the strobe.
    assign alu_res   = alu_eval ? cur_res : noise_res;
    assign alu_flags = flag_latch;

    always @(negedge CLK) noise_res <= 8'($urandom);
    always @(posedge CLK) if (alu_flag_load) flag_latch <= cur_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ir_of(input logic [4:0] op, input logic [2:0] bi);
        int o;
        int r;
        o = int'(op);
        r = 0;
        if (o <= 7) r = 'h87 | (o << 3);
        else if (o == 8) r = 'h3C;
        else if (o == 9) r = 'h3D;
        else if (o <= 17) r = ((o - 10) << 3) | 7;
        else if (o == 18) r = 'h47 | (int'(bi) << 3);
        else if (o == 19) r = 'h87 | (int'(bi) << 3);
        else if (o == 20) r = 'hC7 | (int'(bi) << 3);
        else if (o == 21) r = 'h27;
        else if (o == 22) r = 'h2F;
        else if (o == 23) r = 'h37;
        else if (o == 24) r = 'h3F;
        return 8'(r);
    endfunction

    function automatic logic [23:0] ctl_of(input logic [4:0] op);
        int bits[$];
        logic [23:0] v;
        v = '0;
        case (op)
            5'd0, 5'd1:  bits = '{0, 21, 20, 19};
            5'd2, 5'd3:  bits = '{0, 4, 22, 20, 19};
            5'd4:        bits = '{2, 20, 19};
            5'd5:        bits = '{1, 20, 19};
            5'd6:        bits = '{3, 20, 19};
            5'd7:        bits = '{0, 4, 23, 20, 19};
            5'd8:        bits = '{0, 19};
            5'd9:        bits = '{0, 4, 19};
            5'd10:       bits = '{5, 7, 20, 19};
            5'd11:       bits = '{6, 9, 20, 19};
            5'd12:       bits = '{5, 8, 20, 19};
            5'd13:       bits = '{6, 10, 20, 19};
            5'd14:       bits = '{5, 20, 19};
            5'd15:       bits = '{6, 11, 20, 19};
            5'd16:       bits = '{12, 20, 19};
            5'd17:       bits = '{6, 20, 19};
            5'd18:       bits = '{13, 19};
            5'd19:       bits = '{15};
            5'd20:       bits = '{14};
            5'd21:       bits = '{0, 16, 20, 19};
            5'd22:       bits = '{17, 19};
            5'd23, 5'd24: bits = '{18, 20, 19};
            default:     bits = {};
        endcase
        foreach (bits[i]) v[bits[i]] = 1'b1;
        return v;
    endfunction

    // Returns {result, Z, N, H, C} for the instruction, given the incoming flag state.
    function automatic logic [11:0] alu_model(input logic [4:0] op, input logic [2:0] bi,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] fin);
        int s;
        int cin;
        logic [7:0] r;
        logic z, n, h, c;
        r = '0; z = fin[3]; n = fin[2]; h = fin[1]; c = fin[0];
        cin = ((op == 5'd1) || (op == 5'd3)) ? int'(fin[0]) : 0;
        case (op)
            5'd0, 5'd1: begin
                s = int'(a) + int'(b) + cin; r = 8'(s);
                n = 0; h = (int'(a[3:0]) + int'(b[3:0]) + cin) > 15; c = s > 255;
            end
            5'd2, 5'd3, 5'd7: begin
                s = int'(a) - int'(b) - cin; r = 8'(s);
                n = 1; h = int'(a[3:0]) < (int'(b[3:0]) + cin); c = s < 0;
            end
            5'd4: begin r = a & b; n = 0; h = 1; c = 0; end
            5'd5: begin r = a ^ b; n = 0; h = 0; c = 0; end
            5'd6: begin r = a | b; n = 0; h = 0; c = 0; end
            5'd8: begin r = a + 8'd1; n = 0; h = (a[3:0] == 4'hF); end
            5'd9: begin r = a - 8'd1; n = 1; h = (a[3:0] == 4'h0); end
            5'd10: begin r = {a[6:0], a[7]};   c = a[7]; end
            5'd11: begin r = {a[0], a[7:1]};   c = a[0]; end
            5'd12: begin r = {a[6:0], fin[0]}; c = a[7]; end
            5'd13: begin r = {fin[0], a[7:1]}; c = a[0]; end
            5'd14: begin r = {a[6:0], 1'b0};   c = a[7]; end
            5'd15: begin r = {a[7], a[7:1]};   c = a[0]; end
            5'd16: begin r = {a[3:0], a[7:4]}; c = 0; end
            5'd17: begin r = {1'b0, a[7:1]};   c = a[0]; end
            5'd18: begin r = b; z = ~b[bi]; n = 0; h = 1; end
            5'd19: r = a & ~(8'd1 << bi);
            5'd20: r = a | (8'd1 << bi);
            5'd21: begin
                r = a;
                if (!fin[2]) begin
                    if (fin[0] || a > 8'h99) begin r = r + 8'h60; c = 1; end
                    if (fin[1] || a[3:0] > 4'h9) r = r + 8'h06;
                end else begin
                    if (fin[0]) r = r - 8'h60;
                    if (fin[1]) r = r - 8'h06;
                end
                h = 0;
            end
            5'd22: begin r = ~a; n = 1; h = 1; end
            5'd23: begin r = a; n = 0; h = 0; c = 1; end
            5'd24: begin r = a; n = 0; h = 0; c = ~fin[0]; end
            default: r = '0;
        endcase
        if (op <= 5'd17 || op == 5'd21) z = (r == 8'h00);
        if (op >= 10 && op <= 17) begin n = 0; h = 0; end
        return {r, z, n, h, c};
    endfunction

    task automatic do_cmd(input logic [4:0] op, input logic [2:0] bi, input logic [7:0] a,
                          input logic [7:0] b, input int hold,
                          output logic [7:0] o_res, output logic [3:0] o_flags);
        logic        legal;
        logic        writes;
        logic [11:0] m;
        logic [7:0]  eir;
        logic [7:0]  eres;
        logic [23:0] ectl;
        logic [3:0]  eflags;
        int          cyc;
        int          npre;
        int          neval;
        int          nload;
        legal  = (op <= 5'd24);
        eir    = ir_of(op, bi);
        ectl   = ctl_of(op);
        m      = alu_model(op, bi, a, b, flag_latch);
        writes = ectl[19] | ectl[20];
        eres   = legal ? m[11:4] : 8'h00;
        eflags = legal ? m[3:0] : last_rsp_flags;
        cur_res   = m[11:4];
        cur_flags = m[3:0];
        @(negedge CLK);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_bit = bi; cmd_a = a; cmd_b = b;
        @(negedge CLK);
        cmd_valid = 1'b0; cmd_op = 5'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        cyc = 1; npre = 0; neval = 0; nload = 0;
        while (!rsp_valid && cyc < 20) begin
            npre  += int'(alu_precharge);
            neval += int'(alu_eval);
            nload += int'(alu_flag_load);
            check("busy_ready", 32'(cmd_ready), 32'd0);
            check("ir", 32'(alu_ir), 32'(eir));
            check("ctl", 32'(alu_ctl), 32'(ectl));
            check("opnd1", 32'(alu_opnd1), 32'(a));
            check("opnd2", 32'(alu_opnd2), 32'(b));
            @(negedge CLK);
            cyc++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(cyc), legal ? 32'(4 + EC) : 32'd1);
        check("n_precharge", 32'(npre), legal ? 32'd1 : 32'd0);
        check("n_eval", 32'(neval), legal ? 32'(EC) : 32'd0);
        check("n_flag_load", 32'(nload), (legal && writes) ? 32'd1 : 32'd0);
        check("rsp_res", 32'(rsp_res), 32'(eres));
        check("rsp_flags", 32'(rsp_flags), 32'(eflags));
        check("rsp_err", 32'(rsp_err), legal ? 32'd0 : 32'd1);
        check("resp_ctl_zero", 32'(alu_ctl), 32'd0);
        o_res   = rsp_res;
        o_flags = rsp_flags;
        cmd_valid = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_res", 32'(rsp_res), 32'(eres));
            check("hold_flags", 32'(rsp_flags), 32'(eflags));
            check("hold_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("hs_idle_ready", 32'(cmd_ready), 32'd1);
        check("hs_valid_low", 32'(rsp_valid), 32'd0);
        last_rsp_flags = eflags;
        $display("[TB] op=%0d bit=%0d a=%02h b=%02h -> res=%02h flags=%04b err=%0d latency=%0d",
                 op, bi, a, b, o_res, o_flags, rsp_err, cyc);
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        nRESET = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_bit = '0; cmd_a = '0; cmd_b = '0;
        cur_res = '0; cur_flags = '0; flag_latch = 4'b0100; last_rsp_flags = '0;
        repeat (2) @(negedge CLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_res", 32'(rsp_res), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_strobes", {29'd0, alu_precharge, alu_eval, alu_flag_load}, 32'd0);
        check("rst_ir", 32'(alu_ir), 32'd0);
        nRESET = 1'b1;

        do_cmd(5'd0, 3'd0, 8'h3A, 8'hC6, 0, got_res, got_flags);
        check("add_res", 32'(got_res), 32'h00);
        check("add_flags", 32'(got_flags), 32'b1011);

        do_cmd(5'd18, 3'd7, 8'h00, 8'h80, 0, got_res, got_flags);
        check("bit_flags", 32'(got_flags), 32'b0011);

        do_cmd(5'd20, 3'd3, 8'h00, 8'h55, 0, got_res, got_flags);
        check("set_res", 32'(got_res), 32'h08);

        do_cmd(5'd5, 3'd0, 8'hF0, 8'h3C, 3, got_res, got_flags);
        check("xor_res", 32'(got_res), 32'hCC);

        do_cmd(5'd31, 3'd0, 8'h12, 8'h34, 1, got_res, got_flags);
        check("illegal_res", 32'(got_res), 32'h00);

        // Abort in the middle of evaluation.
        cur_res = 8'h77; cur_flags = 4'b1111;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 5'd2; cmd_a = 8'h91; cmd_b = 8'h22;
        @(negedge CLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!alu_eval && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("reached_eval", 32'(alu_eval), 32'd1);
        #2 nRESET = 1'b0;
        #1;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_strobes", {29'd0, alu_precharge, alu_eval, alu_flag_load}, 32'd0);
        check("abort_ctl", 32'(alu_ctl), 32'd0);
        check("abort_opnd1", 32'(alu_opnd1), 32'd0);
        check("abort_rsp", {22'd0, rsp_valid, rsp_err, rsp_res}, 32'd0);
        check("abort_flags", 32'(rsp_flags), 32'd0);
        @(negedge CLK);
        nRESET = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            n += int'(rsp_valid);
        end
        check("abort_no_rsp", 32'(n), 32'd0);
        last_rsp_flags = '0;
        $display("[TB] reset during eval -> outputs cleared, no response");

        for (int t = 0; t < 40; t++) begin
            do_cmd(5'($urandom_range(0, 31)), 3'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 3), got_res, got_flags);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
